// File: rtl/isqrt_distributor.sv
// Round-robin front end that shares one fixed-latency, in-order isqrt pipeline
// among N_REQ requesters and routes each result back through an in-order tag FIFO.
module isqrt_distributor #(
    parameter int N_REQ        = 3,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_REQ-1:0]                req_vld,
    input  logic [N_REQ*32-1:0]             req_x,
    output logic [N_REQ-1:0]                req_rdy,
    output logic [N_REQ-1:0]                resp_vld,
    output logic [15:0]                     resp_y,
    output logic                            isqrt_x_vld,
    output logic [31:0]                     isqrt_x,
    input  logic                            isqrt_y_vld,
    input  logic [15:0]                     isqrt_y,
    output logic [$clog2(MAX_INFLIGHT):0]   inflight,
    output logic                            err_underflow
);
    localparam int PW = $clog2(N_REQ);
    localparam int AW = $clog2(MAX_INFLIGHT);
    localparam int CW = AW + 1;

    logic [PW-1:0] r_rr_ptr;
    logic [PW-1:0] r_tag [MAX_INFLIGHT];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_err;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_can_issue;
    logic          w_any;
    logic          w_grant;
    logic [PW-1:0] w_win;
    logic [PW-1:0] w_rr_nxt;
    logic [PW-1:0] w_head;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CW'(MAX_INFLIGHT));
    assign w_pop       = isqrt_y_vld & ~w_empty;
    // A slot freed by a same-cycle pop may be reused immediately.
    assign w_can_issue = ~w_full | w_pop;
    assign w_grant     = w_any & w_can_issue;
    assign w_head      = r_tag[r_rd_ptr];

    // Scan from r_rr_ptr upward (mod N_REQ); the first pending requester wins.
    always_comb begin
        logic [PW-1:0] w_idx;
        int            w_sum;
        w_any = 1'b0;
        w_win = '0;
        w_idx = '0;
        w_sum = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = int'(r_rr_ptr) + k;
            if (w_sum >= N_REQ) w_sum = w_sum - N_REQ;
            w_idx = PW'(w_sum);
            if (!w_any && req_vld[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    assign w_rr_nxt = (int'(w_win) == N_REQ - 1) ? '0 : w_win + PW'(1);

    always_comb begin
        req_rdy = '0;
        if (w_grant) req_rdy[w_win] = 1'b1;
    end

    assign isqrt_x_vld = w_grant;
    assign isqrt_x     = req_x[32*w_win +: 32];

    always_comb begin
        resp_vld = '0;
        if (w_pop) resp_vld[w_head] = 1'b1;
    end

    assign resp_y        = isqrt_y;
    assign inflight      = r_count;
    assign err_underflow = r_err;

    // Tag storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (w_grant) r_tag[r_wr_ptr] <= w_win;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_grant) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                r_rr_ptr <= w_rr_nxt;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_grant, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // A result with nothing outstanding has no owner; flag it and drop it.
            if (isqrt_y_vld && w_empty) r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_isqrt_distributor.sv
// Randomized + directed bench: a fixed-latency isqrt model feeds the DUT; an
// issue checker predicts grants and a decoupled monitor scores routed results.
module tb_isqrt_distributor;
    localparam int N  = 3;
    localparam int MI = 4;
    localparam int L  = 6;
    localparam int CW = $clog2(MI) + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_vld;
    logic [N*32-1:0] req_x;
    logic [N-1:0]    req_rdy;
    logic [N-1:0]    resp_vld;
    logic [15:0]     resp_y;
    logic            isqrt_x_vld;
    logic [31:0]     isqrt_x;
    logic            isqrt_y_vld;
    logic [15:0]     isqrt_y;
    logic [CW-1:0]   inflight;
    logic            err_underflow;
    logic            inj_vld;
    logic [15:0]     inj_y;

    always #5 clk = ~clk;

    isqrt_distributor #(.N_REQ(N), .MAX_INFLIGHT(MI)) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_x(req_x), .req_rdy(req_rdy),
        .resp_vld(resp_vld), .resp_y(resp_y), .isqrt_x_vld(isqrt_x_vld), .isqrt_x(isqrt_x),
        .isqrt_y_vld(isqrt_y_vld), .isqrt_y(isqrt_y), .inflight(inflight),
        .err_underflow(err_underflow)
    );

    function automatic logic [15:0] ref_sqrt(input logic [31:0] x);
        longint lo, hi, mid;
        lo = 0;
        hi = 65536;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= longint'(x)) lo = mid;
            else hi = mid;
        end
        return 16'(lo);
    endfunction

    // isqrt pipeline model: L-cycle delay, shares rst with the DUT
    logic        p_v [L];
    logic [31:0] p_x [L];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < L; i++) p_v[i] <= 1'b0;
        end else begin
            p_v[0] <= isqrt_x_vld;
            p_x[0] <= isqrt_x;
            for (int i = 1; i < L; i++) begin
                p_v[i] <= p_v[i-1];
                p_x[i] <= p_x[i-1];
            end
        end
    end
    assign isqrt_y_vld = p_v[L-1] | inj_vld;
    assign isqrt_y     = p_v[L-1] ? ref_sqrt(p_x[L-1]) : inj_y;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct { int id; logic [15:0] y; } exp_t;
    exp_t exp_q[$];

    // Reference model state: round-robin pointer, occupancy, sticky error
    int           m_rr;
    int           m_cnt;
    bit           m_err;
    logic [N-1:0] acc;

    always @(negedge clk) begin : issue_chk
        int           win;
        bit           any, pop, grant;
        logic [N-1:0] er;
        logic [31:0]  xv;
        if (rst) begin
            m_rr  = 0;
            m_cnt = 0;
            m_err = 0;
            acc   = '0;
        end else begin
            any = 0;
            win = 0;
            for (int k = 0; k < N; k++)
                if (!any && req_vld[(m_rr + k) % N]) begin
                    any = 1;
                    win = (m_rr + k) % N;
                end
            pop   = isqrt_y_vld && (m_cnt > 0);
            grant = any && ((m_cnt < MI) || pop);
            er    = '0;
            if (grant) er[win] = 1'b1;
            chk("req_rdy", req_rdy, er);
            chk("isqrt_x_vld", isqrt_x_vld, grant);
            if (grant) begin
                xv = req_x[32*win +: 32];
                chk("isqrt_x", isqrt_x, xv);
                exp_q.push_back('{win, ref_sqrt(xv)});
            end
            chk("inflight", inflight, m_cnt);
            chk("err_underflow", err_underflow, m_err);
            acc = req_vld & req_rdy;
            if (isqrt_y_vld && m_cnt == 0) m_err = 1;
            m_cnt = m_cnt + int'(grant) - int'(pop);
            if (grant) m_rr = (win + 1) % N;
        end
    end

    always @(negedge clk) begin : resp_mon
        exp_t         e;
        logic [N-1:0] er;
        if (rst) begin
            exp_q.delete();
        end else if (resp_vld != '0) begin
            if (exp_q.size() == 0) begin
                chk("resp_spurious", resp_vld, 0);
            end else begin
                e  = exp_q.pop_front();
                er = '0;
                er[e.id] = 1'b1;
                chk("resp_vld", resp_vld, er);
                chk("resp_y", resp_y, e.y);
            end
        end else if (isqrt_y_vld && exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            er = '0;
            er[e.id] = 1'b1;
            chk("resp_missing", resp_vld, er);
        end
    end

    // Advance one cycle; requests accepted last cycle are released.
    task automatic cyc();
        @(posedge clk);
        #1;
        req_vld = req_vld & ~acc;
    endtask

    task automatic put(input int i, input logic [31:0] x);
        req_x[32*i +: 32] = x;
        req_vld[i] = 1'b1;
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while ((req_vld != '0 || exp_q.size() != 0) && n < lim) begin
            cyc();
            n++;
        end
        if (n >= lim) begin
            checks++;
            errors++;
            $display("FAIL wait_idle timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_vld = '0;
        inj_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        req_vld = '0;
        req_x   = '0;
        inj_vld = 1'b0;
        inj_y   = '0;

        // reset state
        do_reset();
        @(negedge clk);
        chk("rst_inflight", inflight, 0);
        chk("rst_err", err_underflow, 0);
        chk("rst_req_rdy", req_rdy, 0);
        chk("rst_resp_vld", resp_vld, 0);
        chk("rst_x_vld", isqrt_x_vld, 0);
        cyc();

        // single request
        put(1, 144);
        @(negedge clk);
        chk("t1_rdy", req_rdy, 3'b010);
        chk("t1_x", isqrt_x, 144);
        cyc();
        wait_idle(40);

        // all three from reset
        do_reset();
        put(0, 4); put(1, 9); put(2, 16);
        wait_idle(40);

        // fairness: req0 granted once (rr -> 1), then req2 must beat req0
        put(0, 49);
        cyc();
        put(0, 64); put(2, 81);
        @(negedge clk);
        chk("t3_fair", req_rdy, 3'b100);
        cyc();
        wait_idle(40);

        // full FIFO: 4 issued, 5th blocked until first result pops
        do_reset();
        put(0, 1); put(1, 4); put(2, 9);
        cyc();
        put(0, 16);
        cyc();
        put(1, 25);
        cyc();
        cyc();
        @(negedge clk);
        chk("t4_inflight_full", inflight, 4);
        chk("t4_blocked", req_rdy, 0);
        cyc();
        cyc();
        @(negedge clk);
        chk("t4_pop_vld", isqrt_y_vld, 1);
        chk("t4_issue_on_pop", req_rdy, 3'b010);
        cyc();
        wait_idle(40);

        // underflow pulse while idle
        inj_y = 16'h1234;
        inj_vld = 1'b1;
        @(negedge clk);
        chk("t5_no_resp", resp_vld, 0);
        chk("t5_err_before", err_underflow, 0);
        cyc();
        inj_vld = 1'b0;
        @(negedge clk);
        chk("t5_err_set", err_underflow, 1);
        repeat (3) cyc();
        @(negedge clk);
        chk("t5_err_sticky", err_underflow, 1);
        cyc();

        // reset with two ops in flight
        put(0, 1000); put(1, 2000);
        cyc();
        cyc();
        rst = 1'b1;
        req_vld = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_inflight", inflight, 0);
        chk("t6_err", err_underflow, 0);
        cyc();
        put(1, 36); put(2, 25);
        @(negedge clk);
        chk("t6_rr_zero", req_rdy, 3'b010);
        cyc();
        wait_idle(40);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (!req_vld[i] && $urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 1) == 0) put(i, $urandom);
                    else put(i, $urandom_range(0, 300) * $urandom_range(0, 300));
                end
            cyc();
        end
        wait_idle(200);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1);
    end

endmodule
